// File: rtl/sa_tx_wr_arb.sv
`default_nettype none
// ============================================================================
//  Module   : sa_tx_wr_arb
//  Brief    : Round-robin per-frame arbiter for the single TX buffer write
//             port shared by the TX control path (CON) and the read/write
//             response path (RW). Forwards only the owner's writes, flags
//             writes from non-owners and revokes grants left idle too long.
//  Revision : 1.0  initial release
// ============================================================================
module sa_tx_wr_arb #(
  parameter int AW      = 11,
  parameter int DW      = 8,
  parameter int TMO_CYC = 1024
) (
  input  logic          sys_clk,
  input  logic          glbl_rst,
  input  logic          con_req,
  output logic          con_gnt,
  input  logic          con_wren,
  input  logic [AW-1:0] con_waddr,
  input  logic [DW-1:0] con_wdata,
  input  logic          rw_req,
  output logic          rw_gnt,
  input  logic          rw_wren,
  input  logic [AW-1:0] rw_waddr,
  input  logic [DW-1:0] rw_wdata,
  output logic          tx_buff_wren,
  output logic [AW-1:0] tx_buff_wraddr,
  output logic [DW-1:0] tx_buff_wrdata,
  input  logic          err_clr,
  output logic          wr_drop_err,
  output logic          tmo_pulse
);

  // Idle counter is one bit wider than needed so it can saturate without wrap.
  localparam int            CW       = $clog2(TMO_CYC) + 1;
  localparam logic [CW-1:0] TMO_LAST = CW'(TMO_CYC - 1);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_OWN_CON = 2'd1,
    ST_OWN_RW  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          last_rw_q, last_rw_d;      // 1: RW was the most recent owner
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mask_con_q, mask_con_d;
  logic          mask_rw_q, mask_rw_d;
  logic          wren_q, wren_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;
  logic          err_q, err_d;
  logic          tmo_q, tmo_d;

  logic w_own_con;
  logic w_own_rw;
  logic w_con_elig;
  logic w_rw_elig;
  logic w_own_req;
  logic w_own_wren;
  logic w_owner_wr;
  logic w_drop;
  logic w_tmo_hit;

  assign w_own_con  = (state_q == ST_OWN_CON);
  assign w_own_rw   = (state_q == ST_OWN_RW);
  // A requester whose grant was revoked must drop req before it is eligible.
  assign w_con_elig = con_req & ~mask_con_q;
  assign w_rw_elig  = rw_req  & ~mask_rw_q;
  assign w_own_req  = (w_own_con & con_req)  | (w_own_rw & rw_req);
  assign w_own_wren = (w_own_con & con_wren) | (w_own_rw & rw_wren);
  assign w_owner_wr = w_own_wren;
  assign w_drop     = (con_wren & ~w_own_con) | (rw_wren & ~w_own_rw);
  // Timeout only revokes a frame still being held; a dropped req is a normal release.
  assign w_tmo_hit  = w_own_req & ~w_own_wren & (cnt_q >= TMO_LAST);

  // State register.
  always_ff @(posedge sys_clk) begin
    if (glbl_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: round-robin on ties, hand over directly when the other side waits.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (w_con_elig && w_rw_elig) begin
          state_d = last_rw_q ? ST_OWN_CON : ST_OWN_RW;
        end else if (w_con_elig) begin
          state_d = ST_OWN_CON;
        end else if (w_rw_elig) begin
          state_d = ST_OWN_RW;
        end
      end
      ST_OWN_CON: begin
        if (!con_req || w_tmo_hit) begin
          state_d = w_rw_elig ? ST_OWN_RW : ST_IDLE;
        end
      end
      ST_OWN_RW: begin
        if (!rw_req || w_tmo_hit) begin
          state_d = w_con_elig ? ST_OWN_CON : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Bookkeeping next-state: last owner, idle counter, revoke masks.
  always_comb begin
    last_rw_d  = last_rw_q;
    cnt_d      = cnt_q;
    mask_con_d = mask_con_q & con_req;
    mask_rw_d  = mask_rw_q & rw_req;

    if (state_d != state_q) begin
      if (w_own_con) begin
        last_rw_d = 1'b0;
      end else if (w_own_rw) begin
        last_rw_d = 1'b1;
      end
    end

    if ((state_d != state_q) || w_owner_wr) begin
      cnt_d = '0;
    end else if (w_own_con || w_own_rw) begin
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : (cnt_q + CNT_ONE);
    end else begin
      cnt_d = '0;
    end

    if (w_tmo_hit && w_own_con) begin
      mask_con_d = 1'b1;
    end
    if (w_tmo_hit && w_own_rw) begin
      mask_rw_d = 1'b1;
    end
  end

  // Write-path next-state: forward only the owner's fields, never merge.
  always_comb begin
    wren_d = w_owner_wr;
    addr_d = addr_q;
    data_d = data_q;
    if (w_own_con && con_wren) begin
      addr_d = con_waddr;
      data_d = con_wdata;
    end else if (w_own_rw && rw_wren) begin
      addr_d = rw_waddr;
      data_d = rw_wdata;
    end
    // A fresh drop beats a simultaneous clear.
    err_d = w_drop | (err_q & ~err_clr);
    tmo_d = w_tmo_hit;
  end

  // Registers for bookkeeping and the write path.
  always_ff @(posedge sys_clk) begin
    if (glbl_rst) begin
      last_rw_q  <= 1'b1;
      cnt_q      <= '0;
      mask_con_q <= 1'b0;
      mask_rw_q  <= 1'b0;
      wren_q     <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      err_q      <= 1'b0;
      tmo_q      <= 1'b0;
    end else begin
      last_rw_q  <= last_rw_d;
      cnt_q      <= cnt_d;
      mask_con_q <= mask_con_d;
      mask_rw_q  <= mask_rw_d;
      wren_q     <= wren_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      err_q      <= err_d;
      tmo_q      <= tmo_d;
    end
  end

  assign con_gnt        = w_own_con;
  assign rw_gnt         = w_own_rw;
  assign tx_buff_wren   = wren_q;
  assign tx_buff_wraddr = addr_q;
  assign tx_buff_wrdata = data_q;
  assign wr_drop_err    = err_q;
  assign tmo_pulse      = tmo_q;

endmodule
`default_nettype wire

// File: tb/tb_sa_tx_wr_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sa_tx_wr_arb
//  Brief    : Self-checking bench for sa_tx_wr_arb: directed frames plus a
//             randomized request/write stream compared with a cycle model.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_sa_tx_wr_arb;

  localparam int AW  = 11;
  localparam int DW  = 8;
  localparam int TMO = 16;

  logic          sys_clk = 1'b0;
  logic          glbl_rst;
  logic          con_req, con_wren, rw_req, rw_wren, err_clr;
  logic [AW-1:0] con_waddr, rw_waddr;
  logic [DW-1:0] con_wdata, rw_wdata;
  logic          con_gnt, rw_gnt, tx_buff_wren, wr_drop_err, tmo_pulse;
  logic [AW-1:0] tx_buff_wraddr;
  logic [DW-1:0] tx_buff_wrdata;

  int checks   = 0;
  int failures = 0;

  // Reference model state: owner 0=none 1=CON 2=RW.
  int            m_own, m_last, m_cnt;
  bit            m_mcon, m_mrw;
  bit            e_wren, e_err, e_tmo;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_data;

  sa_tx_wr_arb #(.AW(AW), .DW(DW), .TMO_CYC(TMO)) dut (
    .sys_clk(sys_clk), .glbl_rst(glbl_rst),
    .con_req(con_req), .con_gnt(con_gnt), .con_wren(con_wren),
    .con_waddr(con_waddr), .con_wdata(con_wdata),
    .rw_req(rw_req), .rw_gnt(rw_gnt), .rw_wren(rw_wren),
    .rw_waddr(rw_waddr), .rw_wdata(rw_wdata),
    .tx_buff_wren(tx_buff_wren), .tx_buff_wraddr(tx_buff_wraddr),
    .tx_buff_wrdata(tx_buff_wrdata), .err_clr(err_clr),
    .wr_drop_err(wr_drop_err), .tmo_pulse(tmo_pulse)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock of the specified behaviour, applied to the inputs the DUT samples.
  task automatic model_step();
    bit ce, re, owr, bad, owner_req, owner_wren, timeout;
    int nxt;
    if (glbl_rst) begin
      m_own = 0; m_last = 2; m_cnt = 0; m_mcon = 0; m_mrw = 0;
      e_wren = 0; e_addr = '0; e_data = '0; e_err = 0; e_tmo = 0;
      return;
    end
    ce = con_req && !m_mcon;
    re = rw_req && !m_mrw;
    owner_req  = (m_own == 1) ? con_req  : (m_own == 2) ? rw_req  : 1'b0;
    owner_wren = (m_own == 1) ? con_wren : (m_own == 2) ? rw_wren : 1'b0;
    owr = owner_wren;
    bad = (con_wren && m_own != 1) || (rw_wren && m_own != 2);
    timeout = owner_req && !owner_wren && (m_cnt >= TMO - 1);

    e_wren = owr;
    if (owr && m_own == 1) begin e_addr = con_waddr; e_data = con_wdata; end
    if (owr && m_own == 2) begin e_addr = rw_waddr;  e_data = rw_wdata;  end
    e_err = bad ? 1'b1 : (err_clr ? 1'b0 : e_err);
    e_tmo = timeout;

    nxt = m_own;
    if (m_own == 0) begin
      if (ce && re) nxt = (m_last == 2) ? 1 : 2;
      else if (ce)  nxt = 1;
      else if (re)  nxt = 2;
    end else if (m_own == 1) begin
      if (!con_req || timeout) nxt = re ? 2 : 0;
    end else begin
      if (!rw_req || timeout) nxt = ce ? 1 : 0;
    end

    if (!con_req) m_mcon = 0;
    if (!rw_req)  m_mrw  = 0;
    if (timeout && m_own == 1) m_mcon = 1;
    if (timeout && m_own == 2) m_mrw  = 1;
    if (nxt != m_own && m_own != 0) m_last = m_own;
    if (nxt != m_own || owr) m_cnt = 0;
    else if (m_own != 0)      m_cnt = m_cnt + 1;
    else                      m_cnt = 0;
    m_own = nxt;
  endtask

  task automatic cycle();
    @(posedge sys_clk);
    model_step();
    #1;
    chk("con_gnt",   32'(con_gnt),        32'(m_own == 1));
    chk("rw_gnt",    32'(rw_gnt),         32'(m_own == 2));
    chk("both_gnt",  32'(con_gnt & rw_gnt), 32'(0));
    chk("wren",      32'(tx_buff_wren),   32'(e_wren));
    chk("waddr",     32'(tx_buff_wraddr), 32'(e_addr));
    chk("wdata",     32'(tx_buff_wrdata), 32'(e_data));
    chk("drop_err",  32'(wr_drop_err),    32'(e_err));
    chk("tmo_pulse", 32'(tmo_pulse),      32'(e_tmo));
  endtask

  task automatic idle_inputs();
    con_req = 0; con_wren = 0; con_waddr = '0; con_wdata = '0;
    rw_req = 0;  rw_wren = 0;  rw_waddr = '0;  rw_wdata = '0;
    err_clr = 0;
  endtask

  task automatic do_reset();
    glbl_rst = 1; idle_inputs();
    cycle(); cycle();
    glbl_rst = 0;
  endtask

  int gnt_cnt, tmo_cnt, wprob;

  initial begin
    glbl_rst = 1; idle_inputs();
    // Reset values
    do_reset();
    chk("rst_con_gnt", 32'(con_gnt), 32'(0));
    chk("rst_err",     32'(wr_drop_err), 32'(0));

    // Basic grant and write latency
    con_req = 1; cycle();
    chk("t1_gnt", 32'(con_gnt), 32'(1));
    con_wren = 1; con_waddr = 11'h010; con_wdata = 8'hA5; cycle();
    chk("t1_wren", 32'(tx_buff_wren), 32'(1));
    chk("t1_addr", 32'(tx_buff_wraddr), 32'(11'h010));
    chk("t1_data", 32'(tx_buff_wrdata), 32'(8'hA5));
    con_wren = 0; cycle();
    chk("t1_wren_off", 32'(tx_buff_wren), 32'(0));

    // Non-owner write while CON owns; sticky error, clear vs new error
    rw_wren = 1; rw_waddr = 11'h7FF; rw_wdata = 8'hFF; cycle();
    chk("t3_nowrite", 32'(tx_buff_wren), 32'(0));
    chk("t3_err", 32'(wr_drop_err), 32'(1));
    rw_wren = 0; cycle(); cycle();
    chk("t3_sticky", 32'(wr_drop_err), 32'(1));
    err_clr = 1; rw_wren = 1; cycle();
    chk("t3_err_wins", 32'(wr_drop_err), 32'(1));
    rw_wren = 0; cycle();
    chk("t3_cleared", 32'(wr_drop_err), 32'(0));
    err_clr = 0;

    // Tie from reset, direct hand-over, round-robin return
    do_reset();
    con_req = 1; rw_req = 1; cycle();
    chk("t2_con_first", 32'(con_gnt), 32'(1));
    cycle();
    con_req = 0; cycle();
    chk("t2_handover", 32'(rw_gnt), 32'(1));
    con_req = 1; cycle(); cycle();
    chk("t2_rw_keeps", 32'(rw_gnt), 32'(1));
    rw_req = 0; cycle();
    chk("t2_back_con", 32'(con_gnt), 32'(1));
    rw_req = 1; con_req = 0; cycle();
    chk("t2_rw_again", 32'(rw_gnt), 32'(1));

    // Timeout revoke and mask
    do_reset();
    con_req = 1; gnt_cnt = 0; tmo_cnt = 0;
    for (int i = 0; i < 22; i++) begin
      cycle();
      if (con_gnt) gnt_cnt++;
      if (tmo_pulse) tmo_cnt++;
    end
    chk("t4_gnt_cycles", 32'(gnt_cnt), 32'(TMO));
    chk("t4_tmo_once",   32'(tmo_cnt), 32'(1));
    chk("t4_masked",     32'(con_gnt), 32'(0));
    con_req = 0; cycle();
    con_req = 1; cycle();
    chk("t4_regrant", 32'(con_gnt), 32'(1));

    // Reset mid-frame while RW writes
    con_req = 0; rw_req = 1; cycle(); cycle();
    rw_wren = 1; rw_waddr = 11'h123; rw_wdata = 8'h5C; cycle();
    glbl_rst = 1; cycle();
    chk("t5_gnt",  32'(rw_gnt), 32'(0));
    chk("t5_wren", 32'(tx_buff_wren), 32'(0));
    chk("t5_addr", 32'(tx_buff_wraddr), 32'(0));
    glbl_rst = 0; rw_wren = 0; con_req = 1; rw_req = 1; cycle();
    chk("t5_tie_con", 32'(con_gnt), 32'(1));

    // Randomized traffic
    idle_inputs(); wprob = 40;
    for (int i = 0; i < 10000; i++) begin
      if (i % 500 == 0) begin
        case ($urandom_range(0, 3))
          0: wprob = 0;
          1: wprob = 3;
          2: wprob = 40;
          default: wprob = 90;
        endcase
      end
      if ($urandom_range(0, 19) == 0) con_req = ~con_req;
      if ($urandom_range(0, 19) == 0) rw_req  = ~rw_req;
      con_wren  = ($urandom_range(0, 99) < wprob);
      rw_wren   = ($urandom_range(0, 99) < wprob);
      con_waddr = AW'($urandom);  con_wdata = DW'($urandom);
      rw_waddr  = AW'($urandom);  rw_wdata  = DW'($urandom);
      err_clr   = ($urandom_range(0, 15) == 0);
      glbl_rst  = ($urandom_range(0, 1999) == 0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
